// File: rtl/aq_gemac_tx_arbiter.sv
`timescale 1ns/1ps
// aq_gemac_tx_arbiter: shares one gigabit TX MAC between queues Q0/Q1 and a pause-frame requester.
// Define AQ_GEMAC_TX_ARB_STRICT_PRIO_EN for fixed Q0-over-Q1 priority; default is round-robin.
module aq_gemac_tx_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_q0_req,
    input  logic             i_q1_req,
    input  logic [7:0]       i_q0_data,
    input  logic [7:0]       i_q1_data,
    input  logic             i_q0_eop,
    input  logic             i_q1_eop,
    output logic             o_q0_rd,
    output logic             o_q1_rd,
    output logic             o_q0_finish,
    output logic             o_q1_finish,
    output logic             o_q0_retry,
    output logic             o_q1_retry,
    output logic             o_q0_drop,
    output logic             o_q1_drop,
    input  logic             i_pause_req,
    output logic             o_tx_req,
    output logic             o_pause_send_enable,
    input  logic             i_buff_rd,
    output logic             o_buff_eop,
    output logic [7:0]       o_buff_data,
    input  logic             i_buff_finish,
    input  logic             i_buff_retry,
    input  logic             i_mac_tx_en,
    input  logic [3:0]       i_max_retry,
    output logic [CNT_W-1:0] o_q0_sent,
    output logic [CNT_W-1:0] o_q1_sent,
    output logic [CNT_W-1:0] o_retry_total,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_FRAME = 2'd1,
        A_PAUSE = 2'd2,
        A_DONE  = 2'd3
    } arb_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t       r_state, w_next;
    logic             r_grant, w_grant_nxt;
    logic             r_pause_frm, w_pfrm_nxt;
    logic             r_armed, w_armed_nxt;
    logic [4:0]       r_rcnt, w_rcnt_nxt;
    logic             r_drop, w_drop_nxt;
    logic             r_pause_pend;
    logic             r_fin_d, r_rty_d;
    logic             r_tx_req, r_pause_en;
    logic [CNT_W-1:0] r_q0_sent, r_q1_sent, r_retry_total;
    logic             w_fin_rise, w_rty_rise;
    logic [4:0]       w_rcnt_inc;
    logic             w_limit;
    logic             w_pick;
    logic             w_retry_pulse, w_drop_pulse, w_finish_pulse;

    assign w_fin_rise = i_buff_finish & ~r_fin_d;
    assign w_rty_rise = i_buff_retry & ~r_rty_d;
    assign w_rcnt_inc = r_rcnt + 5'd1;
    assign w_limit    = (w_rcnt_inc == ({1'b0, i_max_retry} + 5'd2));

`ifdef AQ_GEMAC_TX_ARB_STRICT_PRIO_EN
    assign w_pick = ~i_q0_req;
`else
    // r_last is the queue served most recently; on a tie the other one wins.
    logic r_last;
    assign w_pick = (i_q0_req & i_q1_req) ? ~r_last : ~i_q0_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_last <= 1'b1;
        else if (r_state == A_DONE && !r_pause_frm)
            r_last <= r_grant;
    end
`endif

    always_comb begin
        w_next         = r_state;
        w_grant_nxt    = r_grant;
        w_pfrm_nxt     = r_pause_frm;
        w_armed_nxt    = r_armed;
        w_rcnt_nxt     = r_rcnt;
        w_drop_nxt     = r_drop;
        w_retry_pulse  = 1'b0;
        w_drop_pulse   = 1'b0;
        w_finish_pulse = 1'b0;
        case (r_state)
            A_IDLE: begin
                if (r_pause_pend) begin
                    w_next     = A_PAUSE;
                    w_pfrm_nxt = 1'b1;
                end else if (i_q0_req || i_q1_req) begin
                    w_next      = A_FRAME;
                    w_pfrm_nxt  = 1'b0;
                    w_grant_nxt = w_pick;
                end
            end
            A_FRAME, A_PAUSE: begin
                // A collision edge wins over a same-cycle finish edge. At the retry limit
                // armed stays set so the MAC's closing BUFF_FINISH still ends the transfer.
                if (w_rty_rise) begin
                    w_rcnt_nxt  = w_rcnt_inc;
                    w_armed_nxt = w_limit | r_drop;
                    if (r_state == A_FRAME && !r_drop) begin
                        if (w_limit) begin
                            w_drop_pulse = 1'b1;
                            w_drop_nxt   = 1'b1;
                        end else begin
                            w_retry_pulse = 1'b1;
                        end
                    end
                end else begin
                    w_armed_nxt = r_armed | i_mac_tx_en;
                    if (w_fin_rise && r_armed)
                        w_next = A_DONE;
                end
            end
            A_DONE: begin
                w_finish_pulse = ~r_pause_frm & ~r_drop;
                w_armed_nxt    = 1'b0;
                w_rcnt_nxt     = 5'd0;
                w_drop_nxt     = 1'b0;
                w_next         = A_IDLE;
            end
            default: w_next = A_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= A_IDLE;
            r_grant       <= 1'b0;
            r_pause_frm   <= 1'b0;
            r_armed       <= 1'b0;
            r_rcnt        <= 5'd0;
            r_drop        <= 1'b0;
            r_pause_pend  <= 1'b0;
            r_fin_d       <= 1'b0;
            r_rty_d       <= 1'b0;
            r_tx_req      <= 1'b0;
            r_pause_en    <= 1'b0;
            r_q0_sent     <= '0;
            r_q1_sent     <= '0;
            r_retry_total <= '0;
        end else begin
            r_state      <= w_next;
            r_grant      <= w_grant_nxt;
            r_pause_frm  <= w_pfrm_nxt;
            r_armed      <= w_armed_nxt;
            r_rcnt       <= w_rcnt_nxt;
            r_drop       <= w_drop_nxt;
            r_pause_pend <= i_pause_req | (r_pause_pend & (r_state != A_IDLE));
            r_fin_d      <= i_buff_finish;
            r_rty_d      <= i_buff_retry;
            r_tx_req     <= (w_next == A_FRAME);
            r_pause_en   <= (w_next == A_PAUSE);
            if (w_finish_pulse && !r_grant)
                r_q0_sent <= r_q0_sent + CNT_ONE;
            if (w_finish_pulse && r_grant)
                r_q1_sent <= r_q1_sent + CNT_ONE;
            if (w_rty_rise)
                r_retry_total <= r_retry_total + CNT_ONE;
        end
    end

    // Qn_RD is a pop strobe: the head byte is consumed on every cycle where the MAC reads.
    assign o_q0_rd             = (r_state == A_FRAME) & i_buff_rd & ~r_grant;
    assign o_q1_rd             = (r_state == A_FRAME) & i_buff_rd & r_grant;
    assign o_buff_data         = (r_state != A_FRAME) ? 8'd0 : (r_grant ? i_q1_data : i_q0_data);
    assign o_buff_eop          = (r_state == A_FRAME) & (r_grant ? i_q1_eop : i_q0_eop);
    assign o_q0_finish         = w_finish_pulse & ~r_grant;
    assign o_q1_finish         = w_finish_pulse & r_grant;
    assign o_q0_retry          = w_retry_pulse & ~r_grant;
    assign o_q1_retry          = w_retry_pulse & r_grant;
    assign o_q0_drop           = w_drop_pulse & ~r_grant;
    assign o_q1_drop           = w_drop_pulse & r_grant;
    assign o_tx_req            = r_tx_req;
    assign o_pause_send_enable = r_pause_en;
    assign o_q0_sent           = r_q0_sent;
    assign o_q1_sent           = r_q1_sent;
    assign o_retry_total       = r_retry_total;
    assign o_state             = r_state;

endmodule

// File: tb/tb_aq_gemac_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for aq_gemac_tx_arbiter: a MAC emulator drives transfers, a frame-level model predicts
// grants, completions, retries, drops and statistics.
module tb_aq_gemac_tx_arbiter;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic q0_req = 0, q1_req = 0, q0_eop = 0, q1_eop = 0;
  logic [7:0] q0_data = 8'h00, q1_data = 8'h00;
  logic pause_req = 0, buff_rd = 0, buff_finish = 0, buff_retry = 0, mac_tx_en = 0;
  logic [3:0] max_retry = 4'd1;
  logic q0_rd, q1_rd, q0_finish, q1_finish, q0_retry, q1_retry, q0_drop, q1_drop;
  logic tx_req, pause_en, buff_eop;
  logic [7:0] buff_data;
  logic [CNT_W-1:0] q0_sent, q1_sent, retry_total;
  logic [1:0] dbg_state;

  aq_gemac_tx_arbiter #(.CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_q0_req(q0_req), .i_q1_req(q1_req),
    .i_q0_data(q0_data), .i_q1_data(q1_data),
    .i_q0_eop(q0_eop), .i_q1_eop(q1_eop),
    .o_q0_rd(q0_rd), .o_q1_rd(q1_rd),
    .o_q0_finish(q0_finish), .o_q1_finish(q1_finish),
    .o_q0_retry(q0_retry), .o_q1_retry(q1_retry),
    .o_q0_drop(q0_drop), .o_q1_drop(q1_drop),
    .i_pause_req(pause_req),
    .o_tx_req(tx_req), .o_pause_send_enable(pause_en),
    .i_buff_rd(buff_rd), .o_buff_eop(buff_eop), .o_buff_data(buff_data),
    .i_buff_finish(buff_finish), .i_buff_retry(buff_retry), .i_mac_tx_en(mac_tx_en),
    .i_max_retry(max_retry),
    .o_q0_sent(q0_sent), .o_q1_sent(q1_sent), .o_retry_total(retry_total),
    .o_state(dbg_state)
  );

  // clock / reset
  always #4 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulse monitor
  int mon_fin[2] = '{0, 0};
  int mon_rty[2] = '{0, 0};
  int mon_drp[2] = '{0, 0};
  int mon_bad = 0;
  always @(negedge clk) begin
    if (q0_finish) mon_fin[0]++;
    if (q1_finish) mon_fin[1]++;
    if (q0_retry)  mon_rty[0]++;
    if (q1_retry)  mon_rty[1]++;
    if (q0_drop)   mon_drp[0]++;
    if (q1_drop)   mon_drp[1]++;
    if (tx_req && pause_en) mon_bad++;
  end

  // reference model: frame-level view of the arbiter
  logic m_last;
  bit   m_pend;
  int   m_sent[2];
  int   m_total;
  int   m_max;
  logic last_g;
  logic [0:0] exp_q[$];

  task automatic model_reset();
    m_last = 1'b1;
    m_pend = 0;
    m_sent[0] = 0;
    m_sent[1] = 0;
    m_total = 0;
    exp_q.delete();
  endtask

  function automatic logic m_pick(input logic r0, input logic r1);
`ifdef AQ_GEMAC_TX_ARB_STRICT_PRIO_EN
    return r0 ? 1'b0 : 1'b1;
`else
    if (r0 && r1) return ~m_last;
    return r0 ? 1'b0 : 1'b1;
`endif
  endfunction

  // MAC emulator: one collided attempt (transmit, jam, post-backoff defer)
  task automatic jam();
    mac_tx_en = 1; buff_rd = 1; tick(); tick();
    mac_tx_en = 0; buff_rd = 0; tick();
    buff_retry = 1; tick(); tick();
    buff_retry = 0; tick();
    buff_finish = 1; tick(); tick();
    buff_finish = 0; tick();
  endtask

  task automatic success();
    mac_tx_en = 1; buff_rd = 1; tick(); tick(); tick();
    mac_tx_en = 0; buff_rd = 0; tick();
    buff_finish = 1; tick(); tick();
    buff_finish = 0; tick();
  endtask

  task automatic wait_grant();
    bit ok;
    logic [0:0] e;
    ok = 0;
    e = exp_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_req) begin ok = 1; break; end
    end
    if (!ok) begin
      check("grant_timeout", {31'd0, tx_req}, 32'd1);
      return;
    end
    buff_rd = 1;
    #1;
    last_g = q1_rd;
    check("grant_rd", {30'd0, q1_rd, q0_rd}, e ? 32'd2 : 32'd1);
    check("grant_data", {24'd0, buff_data}, {24'd0, (e ? q1_data : q0_data)});
    buff_rd = 0;
    tick();
  endtask

  task automatic open_frame(input logic r0, input logic r1, input bit keep, output logic eg);
    eg = m_pick(r0, r1);
    exp_q.push_back(eg);
    q0_data = 8'($urandom);
    q1_data = 8'($urandom);
    q0_req = r0;
    q1_req = r1;
    wait_grant();
    if (!keep) begin q0_req = 0; q1_req = 0; end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_q0_sent"}, {16'd0, q0_sent}, m_sent[0]);
    check({tag, "_q1_sent"}, {16'd0, q1_sent}, m_sent[1]);
    check({tag, "_retry_total"}, {16'd0, retry_total}, m_total & 32'hFFFF);
  endtask

  task automatic close_frame(input logic eg, input int ncoll, input bit do_pause);
    int sf, sr, sd, so;
    bit drop;
    sf = mon_fin[eg]; sr = mon_rty[eg]; sd = mon_drp[eg];
    so = mon_fin[~eg] + mon_rty[~eg] + mon_drp[~eg];
    drop = (ncoll == m_max + 2);
    tick();
    pause_req = do_pause; tick();
    pause_req = 0;
    for (int k = 0; k < ncoll; k++) jam();
    if (!drop) success();
    m_last = eg;
    if (!drop) m_sent[eg]++;
    m_total += ncoll;
    if (do_pause) m_pend = 1;
    check("finish_cnt", mon_fin[eg] - sf, drop ? 0 : 1);
    check("retry_cnt", mon_rty[eg] - sr, drop ? ncoll - 1 : ncoll);
    check("drop_cnt", mon_drp[eg] - sd, drop ? 1 : 0);
    check("other_q_pulses", mon_fin[~eg] + mon_rty[~eg] + mon_drp[~eg] - so, 0);
    check_stats("frame");
  endtask

  task automatic run_pause();
    bit ok;
    int s;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pause_en) begin ok = 1; break; end
    end
    check("pause_start", {31'd0, pause_en}, 32'd1);
    if (!ok) return;
    s = mon_fin[0] + mon_fin[1] + mon_rty[0] + mon_rty[1] + mon_drp[0] + mon_drp[1];
    q0_eop = 1; q1_eop = 1; q0_data = 8'hFF; q1_data = 8'hFF; buff_rd = 1;
    #1;
    check("pause_tx_req", {31'd0, tx_req}, 32'd0);
    check("pause_bus", {21'd0, q0_rd, q1_rd, buff_eop, buff_data}, 32'd0);
    buff_rd = 0; q0_eop = 0; q1_eop = 0;
    tick();
    jam();
    success();
    m_total += 1;
    m_pend = 0;
    check("pause_no_q_pulse",
          mon_fin[0] + mon_fin[1] + mon_rty[0] + mon_rty[1] + mon_drp[0] + mon_drp[1] - s, 0);
    repeat (6) tick();
    check("pause_once", {30'd0, pause_en, tx_req}, 32'd0);
    check_stats("pause");
  endtask

  task automatic run_data(input logic r0, input logic r1, input int ncoll, input bit do_pause,
                          input bit keep);
    logic eg;
    open_frame(r0, r1, keep, eg);
    close_frame(eg, ncoll, do_pause);
    if (m_pend) run_pause();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_tx_req"}, {31'd0, tx_req}, 32'd0);
    check({tag, "_pause_en"}, {31'd0, pause_en}, 32'd0);
    check({tag, "_rd"}, {30'd0, q1_rd, q0_rd}, 32'd0);
    check({tag, "_bus"}, {23'd0, buff_eop, buff_data}, 32'd0);
    check({tag, "_pulses"}, {26'd0, q0_finish, q1_finish, q0_retry, q1_retry, q0_drop, q1_drop},
          32'd0);
    check({tag, "_counters"}, {q0_sent, q1_sent} | {16'd0, retry_total}, 32'd0);
  endtask

  typedef struct {
    logic       gnt;
    logic       rd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       e0;
    logic       e1;
    logic       x_rd0;
    logic       x_rd1;
    logic [7:0] x_data;
    logic       x_eop;
  } vec_t;

  vec_t tbl[8];
  logic [3:0] g_seq;
  logic [3:0] exp_seq;

  initial begin
    logic eg;
    tbl[0] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 8'h7E, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0};

    // reset with live inputs: outputs must stay quiet
    model_reset();
    m_max = 1;
    q0_req = 1; q1_req = 1; q0_data = 8'h5A; q1_data = 8'hC3; q0_eop = 1; q1_eop = 1;
    buff_rd = 1; buff_retry = 1; buff_finish = 1; mac_tx_en = 1;
    repeat (3) tick();
    check_quiet("reset");
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    q0_req = 0; q1_req = 0; q0_eop = 0; q1_eop = 0;
    buff_rd = 0; buff_retry = 0; buff_finish = 0; mac_tx_en = 0;
    tick();
    rst_n = 1;
    tick();

    // both queues requesting continuously, four clean frames
    for (int i = 0; i < 4; i++) begin
      run_data(1'b1, 1'b1, 0, 1'b0, i < 3);
      g_seq[i] = last_g;
    end
`ifdef AQ_GEMAC_TX_ARB_STRICT_PRIO_EN
    exp_seq = 4'b0000;
    check("rr_q0_sent", {16'd0, q0_sent}, 32'd4);
    check("rr_q1_sent", {16'd0, q1_sent}, 32'd0);
`else
    exp_seq = 4'b1010;
    check("rr_q0_sent", {16'd0, q0_sent}, 32'd2);
    check("rr_q1_sent", {16'd0, q1_sent}, 32'd2);
`endif
    check("rr_sequence", {28'd0, g_seq}, {28'd0, exp_seq});
    repeat (4) tick();

    // data path mux vectors
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || tbl[i].gnt != tbl[i-1].gnt) begin
        if (i != 0) close_frame(tbl[i-1].gnt, 0, 1'b0);
        open_frame(~tbl[i].gnt, tbl[i].gnt, 1'b0, eg);
      end
      buff_rd = tbl[i].rd; q0_data = tbl[i].d0; q1_data = tbl[i].d1;
      q0_eop = tbl[i].e0; q1_eop = tbl[i].e1;
      @(negedge clk);
      check($sformatf("vec%0d_rd0", i), {31'd0, q0_rd}, {31'd0, tbl[i].x_rd0});
      check($sformatf("vec%0d_rd1", i), {31'd0, q1_rd}, {31'd0, tbl[i].x_rd1});
      check($sformatf("vec%0d_data", i), {24'd0, buff_data}, {24'd0, tbl[i].x_data});
      check($sformatf("vec%0d_eop", i), {31'd0, buff_eop}, {31'd0, tbl[i].x_eop});
      tick();
    end
    buff_rd = 0; q0_eop = 0; q1_eop = 0;
    close_frame(tbl[7].gnt, 0, 1'b0);

    // pause requested while a Q1 frame is in flight
    run_data(1'b0, 1'b1, 0, 1'b1, 1'b0);

    // retry limit 1: two retries then drop; then one collision followed by success
    max_retry = 4'd1; m_max = 1;
    run_data(1'b1, 1'b0, 3, 1'b0, 1'b0);
    run_data(1'b1, 1'b0, 1, 1'b0, 1'b0);

    // simultaneous finish and retry edges: retry must win
    begin
      int sf, sr;
      max_retry = 4'd3; m_max = 3;
      open_frame(1'b1, 1'b0, 1'b0, eg);
      sf = mon_fin[0]; sr = mon_rty[0];
      mac_tx_en = 1; buff_rd = 1; tick(); tick();
      mac_tx_en = 0; buff_rd = 0; tick();
      buff_retry = 1; buff_finish = 1;
      @(negedge clk);
      check("fin_rty_retry", {31'd0, q0_retry}, 32'd1);
      tick(); tick();
      buff_retry = 0; buff_finish = 0; tick(); tick();
      check("fin_rty_no_done", {30'd0, dbg_state}, 32'd1);
      check("fin_rty_no_finish", mon_fin[0] - sf, 0);
      success();
      m_last = 1'b0; m_sent[0]++; m_total++;
      check("fin_rty_finish", mon_fin[0] - sf, 1);
      check("fin_rty_retry_cnt", mon_rty[0] - sr, 1);
      check_stats("fin_rty");
    end

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int mx, nc, rp;
      bit pz;
      mx = $urandom_range(0, 3);
      max_retry = mx[3:0];
      m_max = mx;
      rp = $urandom_range(1, 3);
      nc = $urandom_range(0, mx + 2);
      pz = ($urandom_range(0, 3) == 0);
      run_data(rp[0], rp[1], nc, pz, 1'b0);
    end

    // asynchronous reset mid-frame, Q1 still requesting afterwards
    open_frame(1'b0, 1'b1, 1'b1, eg);
    q0_data = 8'h99; q1_data = 8'h66; q1_eop = 1;
    mac_tx_en = 1; buff_rd = 1;
    tick();
    #1 rst_n = 0;
    #1 check_quiet("async_rst");
    mac_tx_en = 0; buff_rd = 0; q1_eop = 0;
    tick(); tick();
    rst_n = 1;
    model_reset();
    tick();
    run_data(1'b0, 1'b1, 0, 1'b0, 1'b0);

    check("no_tx_req_with_pause", mon_bad, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aq_gemac_tx_arbiter.md
# aq_gemac_tx_arbiter

Shares the single gigabit TX MAC between two transmit frame queues (Q0, Q1) and a pause-frame requester. Sits between the TX buffers and the TX MAC buffer interface: muxes data and EOP, drives TX_REQ and PAUSE_SEND_ENABLE, and returns per-queue completion, retry and drop events. Tracks MAC retries itself so the MAC's late-collision drop path is reported correctly.

## Interface
- CNT_W, 16, width of the per-queue sent-frame and retry statistics counters.
- CLK  in  1  MAC clock, same clock as the TX MAC.
- RST_N  in  1  reset; one clock, reset is asynchronous and active-low.
- Q0_REQ / Q1_REQ  in  1  queue holds at least one complete frame.
- Q0_DATA / Q1_DATA  in  8  queue head byte.
- Q0_EOP / Q1_EOP  in  1  queue head byte is the last byte of its frame.
- Q0_RD / Q1_RD  out  1  pop strobe to the queue.
- Q0_FINISH / Q1_FINISH  out  1  one-cycle pulse: frame sent, release it.
- Q0_RETRY / Q1_RETRY  out  1  one-cycle pulse: collision, rewind to frame start.
- Q0_DROP / Q1_DROP  out  1  one-cycle pulse: retry limit exceeded, discard the frame and flush to EOP.
- PAUSE_REQ  in  1  pulse: send one pause frame.
- TX_REQ  out  1  to MAC.
- PAUSE_SEND_ENABLE  out  1  to MAC.
- BUFF_RD  in  1  from MAC, already RunMode-gated.
- BUFF_EOP  out  1  to MAC.
- BUFF_DATA  out  8  to MAC.
- BUFF_FINISH  in  1  from MAC, high while the MAC is deferring.
- BUFF_RETRY  in  1  from MAC, high while the MAC is jamming.
- MAC_TX_EN  in  1  MAC TX_EN.
- MAX_RETRY  in  4  same value as driven to the MAC; 0..14 supported.
- Q0_SENT / Q1_SENT  out  CNT_W  frames finished, wrapping.
- RETRY_TOTAL  out  CNT_W  BUFF_RETRY rising edges, wrapping.

## Operation
- States: A_IDLE, A_FRAME, A_PAUSE, A_DONE.
- Edge detects are registered: fin_rise = BUFF_FINISH & ~fin_d; rty_rise = BUFF_RETRY & ~rty_d.
- pause_pend: set by PAUSE_REQ in any state, including A_PAUSE; cleared on entry to A_PAUSE.
- A_IDLE selection order, evaluated in one cycle:
  1. pause_pend goes to A_PAUSE.
  2. Otherwise a requesting queue goes to A_FRAME and latches grant.
  3. Tie between Q0 and Q1: round-robin; the queue not served last wins. Pointer resets to favour Q0.
- A_FRAME:
  - TX_REQ=1.
  - Qn_RD = BUFF_RD & (grant==n).
  - BUFF_DATA = granted Qn_DATA; BUFF_EOP = granted Qn_EOP.
  - armed set by MAC_TX_EN.
  - On rty_rise: armed cleared, rcnt incremented (5 bits).
    - If rcnt reaches MAX_RETRY+2: pulse Qn_DROP, set drop flag, keep armed=1.
    - Otherwise pulse Qn_RETRY.
  - fin_rise & armed goes to A_DONE.
  - fin_rise & ~armed is ignored (post-backoff defer).
- A_PAUSE:
  - PAUSE_SEND_ENABLE=1, TX_REQ=0, BUFF_DATA=0, BUFF_EOP=0.
  - armed/retry handling as in A_FRAME, with no queue pulses.
  - A pause frame is never dropped by the arbiter.
  - fin_rise & armed goes to A_DONE.
- A_DONE (one cycle):
  - TX_REQ=0, PAUSE_SEND_ENABLE=0.
  - If data frame without drop: pulse Qn_FINISH and increment Qn_SENT.
  - Update the RR pointer, clear armed/rcnt/drop, go to A_IDLE.
- Outside A_FRAME: all Qn_RD=0, BUFF_EOP=0, BUFF_DATA=0.
- Simultaneous fin_rise and rty_rise: rty_rise is processed first, so completion is not taken that cycle.

## Timing
- Reset values: all outputs 0, state A_IDLE, counters 0.
- Reset mid-frame aborts with no FINISH/RETRY/DROP pulse.
- TX_REQ and PAUSE_SEND_ENABLE are registered.
- Request sampled in A_IDLE leads to TX_REQ asserted on the next cycle.
- fin_rise leads to Qn_FINISH one cycle later (A_DONE).
- Earliest re-grant: 2 cycles after fin_rise. This is within the MAC IFG, so the MAC never samples a stale TX_REQ.
- Qn_RD, BUFF_DATA, BUFF_EOP are combinational from the registered grant; no added read latency.
- 10/100 mode (half-rate MAC): edge detection tolerates multi-cycle BUFF_FINISH/BUFF_RETRY levels.

## Configuration
- AQ_GEMAC_TX_ARB_STRICT_PRIO_EN:
  - Defined: Q0 always beats Q1; the RR pointer is not implemented.
  - Undefined: round-robin as above.
- Pause priority is unaffected either way.

## Test plan
- Q0_REQ=Q1_REQ=1 continuously, 4 frames, no collisions -> grants Q0,Q1,Q0,Q1; Q0_SENT=Q1_SENT=2. Strict-prio build: Q0 ×4.
- PAUSE_REQ pulse while a Q1 frame is in A_FRAME -> Q1 completes with Q1_FINISH, then PAUSE_SEND_ENABLE=1 for exactly one pause frame; no Qn pulse for the pause.
- MAX_RETRY=1, half duplex, TX_CRS forced during each preamble -> Q0_RETRY on jams 1 and 2, Q0_DROP on jam 3; no Q0_FINISH; Q0_SENT unchanged; RETRY_TOTAL=3.
- One collision then success -> one Q0_RETRY; the BUFF_FINISH rise after backoff is ignored; exactly one Q0_FINISH after the real completion.
- RST_N low mid-A_FRAME -> all outputs 0 asynchronously; after release, the pending Q1 request is granted fresh.
